d_memory_param: RTL and testbench
=================================

Name: d_memory_param

Overview:
- Next-generation data memory for the pipelined CPU; replaces the fixed 16x256 D_MEMORY.
- Width and depth are parametrised, with configurable wait states and a request/ready/ack handshake.
- After reset, a hardware clear-sweep initialises every word to a known value.
- Sits between the CPU data port (d_addr/d_dataout/d_we) and the bench or SoC fabric; the CPU stalls on ready=0.

Parameters:
- DATA_W, 16, data word width in bits (>=8)
- ADDR_W, 8, address width in bits
- DEPTH, 256, number of words; power of two, <= 2**ADDR_W
- WAIT_CYC, 0, extra wait states per access (0..15)
- INIT_VAL, 0, value written to every word by the clear-sweep

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  access request; sampled only when ready=1
- we  in  1  1=write, 0=read; qualified by req
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  read data; registered, held until the next read ack
- ready  out  1  block can accept a request this cycle
- ack  out  1  one-cycle completion pulse (reads and writes)
- busy  out  1  clear-sweep in progress

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset (rst=1 at an edge):
  - ready=0, ack=0, rdata=0, busy=1; internal sweep index=0; state=CLEAR.
  - Any in-flight access is aborted; a pending write that has not yet been committed is dropped.
- FSM states: CLEAR, IDLE, WAIT, RESP.
- CLEAR:
  - Each cycle, writes INIT_VAL to mem[index] and increments index.
  - After writing index DEPTH-1: busy=0, go to IDLE. The sweep takes exactly DEPTH cycles after rst falls.
  - ready=0 throughout; req is ignored (not queued).
- IDLE:
  - ready=1.
  - On an edge with req=1, the request is accepted and addr/we/wdata are latched.
  - A write commits to the array at the acceptance edge.
  - A read captures mem[addr] at the acceptance edge.
  - Next state: WAIT_CYC=0 -> RESP; otherwise WAIT with counter=WAIT_CYC-1.
- WAIT:
  - ready=0; counter decrements each cycle.
  - When counter=0, go to RESP.
  - req is ignored.
- RESP:
  - ack=1 for exactly one cycle.
  - Read: rdata is updated to the captured word at the edge entering RESP.
  - Write: rdata is unchanged.
  - ready=1 in RESP, so a new request may be accepted at the edge leaving RESP (back-to-back).
- Latency:
  - Acceptance at edge k -> ack high from edge k+1+WAIT_CYC.
  - Throughput: one access per 1+WAIT_CYC cycles.
  - With WAIT_CYC=0, ready stays high and one access is accepted per cycle.
- Ordering: a read accepted at the edge after a write to the same address returns the new data. No read-during-write hazard, because writes commit at acceptance.
- Address wrap: effective address = addr[log2(DEPTH)-1:0]; upper bits are ignored.
- Simultaneous rst and req: rst wins.
- req with we=1 during WAIT or CLEAR: no array change.
- Widths: the array is DEPTH x DATA_W. Default parameters are bit-compatible with the existing CPU data port (16-bit data, 8-bit address).
- The I_MEMORY-style bench preload by hierarchical assignment remains legal: the array is named D_RAM and is indexable. Preload must happen after the sweep completes.

Optional Feature:
- Macro: DMEM_BOUNDS_CHK_EN.
- Defined:
  - Adds output port err (1 bit, reset 0).
  - Addresses >= DEPTH are not wrapped.
  - Out-of-range writes are dropped; out-of-range reads return 0.
  - err=1 in the same cycle as the ack for that access, 0 otherwise.
- Undefined: no err port; addresses wrap as described in Behaviour.

Test Plan:
1. Reset sweep: preload D_RAM[5]=16'h1234 before reset, INIT_VAL=16'hA5A5, assert rst for 2 cycles -> busy high for exactly 256 cycles after release, ready=0 during that time, then read addr 5 returns 16'hA5A5.
2. Back-to-back, WAIT_CYC=0:
   - Write addr 2=16'd325, then read addr 2 on the very next cycle -> ack on consecutive cycles, rdata=16'd325 with the second ack.
   - ready never drops.
3. Wait states, WAIT_CYC=3:
   - Read addr 0 (preloaded 16'h00AB) -> ack exactly 4 cycles after acceptance, ready=0 for 3 cycles, rdata=16'h00AB.
   - A req pulsed during the wait is ignored.
4. Wrap (macro off), DEPTH=16, ADDR_W=8:
   - Write addr 8'h13=16'h3C00 -> read addr 3 returns 16'h3C00.
   - Macro on: the same write gives err=1 with ack, and addr 3 is unchanged.
5. Reset mid-operation, WAIT_CYC=2:
   - Accept a read, assert rst during WAIT -> no ack, rdata=0, sweep restarts (busy=1), and ready returns only after DEPTH cycles.
6. CPU loop regression: PIPE_CPU 25-iteration sum program with this memory (defaults, WAIT_CYC=0) -> D_RAM[2]=16'd325 at HALT.

Source files
------------

// File: rtl/d_memory_param_if.sv
// Bus bundle between a CPU data port (master) and d_memory_param (slave).
// The err signal only exists when DMEM_BOUNDS_CHK_EN is defined.
interface d_memory_param_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              ack;
    logic              busy;
`ifdef DMEM_BOUNDS_CHK_EN
    logic              err;
`endif

    modport master (
`ifdef DMEM_BOUNDS_CHK_EN
        input  err,
`endif
        output req, we, addr, wdata,
        input  rdata, ready, ack, busy
    );

    modport slave (
`ifdef DMEM_BOUNDS_CHK_EN
        output err,
`endif
        input  req, we, addr, wdata,
        output rdata, ready, ack, busy
    );
endinterface

// File: rtl/d_memory_param.sv
// Parametrised data memory with wait states, req/ready/ack handshake and post-reset clear sweep.
// Optional macro DMEM_BOUNDS_CHK_EN: reject addresses >= DEPTH and flag them on err.
module d_memory_param #(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter int                WAIT_CYC = 0,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input logic              clk,
    input logic              rst,
    d_memory_param_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] ST_CLEAR = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [3:0]       WAIT_INIT = 4'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);

    logic [DATA_W-1:0] D_RAM [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] capWord_q, capWord_d;
    logic              isRead_q, isRead_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic [IDX_W-1:0]  effIdx;
    logic              inRange;
    logic              ready;
    logic              accept;
    logic [DATA_W-1:0] memWord;

    assign effIdx  = bus.addr[IDX_W-1:0];
    assign ready   = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign accept  = ready && bus.req;
    assign memWord = inRange ? D_RAM[effIdx] : '0;

`ifdef DMEM_BOUNDS_CHK_EN
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
    logic errFlag_q, errFlag_d;

    assign inRange = ({1'b0, bus.addr} < DEPTH_L);
    assign bus.err = (state_q == ST_RESP) && errFlag_q;
`else
    assign inRange = 1'b1;
`endif

    assign bus.ready = ready;
    assign bus.ack   = (state_q == ST_RESP);
    assign bus.busy  = (state_q == ST_CLEAR);
    assign bus.rdata = rdata_q;

    // Reads are captured at acceptance, so the array is never read after a
    // later write could have changed it; rdata only moves when entering RESP.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        capWord_d = capWord_q;
        isRead_d  = isRead_q;
        rdata_d   = rdata_q;
`ifdef DMEM_BOUNDS_CHK_EN
        errFlag_d = errFlag_q;
`endif
        case (state_q)
            ST_CLEAR: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    if (isRead_q) rdata_d = capWord_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (bus.req) begin
                    isRead_d  = !bus.we;
                    capWord_d = memWord;
`ifdef DMEM_BOUNDS_CHK_EN
                    errFlag_d = !inRange;
`endif
                    if (WAIT_CYC == 0) begin
                        state_d = ST_RESP;
                        if (!bus.we) rdata_d = memWord;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            idx_q     <= '0;
            cnt_q     <= '0;
            capWord_q <= '0;
            isRead_q  <= 1'b0;
            rdata_q   <= '0;
`ifdef DMEM_BOUNDS_CHK_EN
            errFlag_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            capWord_q <= capWord_d;
            isRead_q  <= isRead_d;
            rdata_q   <= rdata_d;
`ifdef DMEM_BOUNDS_CHK_EN
            errFlag_q <= errFlag_d;
`endif
        end
    end

    // The array has no reset of its own; the sweep after reset initialises it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR)
                D_RAM[idx_q] <= INIT_VAL;
            else if (accept && bus.we && inRange)
                D_RAM[effIdx] <= bus.wdata;
        end
    end
endmodule

// File: tb/tb_d_memory_param.sv
// Directed bench for d_memory_param: instance A uses default geometry with no wait states,
// instance B uses DEPTH=16 and WAIT_CYC=3 for wait-state, wrap and mid-access reset checks.
module tb_d_memory_param;
    logic clk = 1'b0;
    logic rstA;
    logic rstB;
    int   checks = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    d_memory_param_if #(.DATA_W(16), .ADDR_W(8)) ifA ();
    d_memory_param_if #(.DATA_W(16), .ADDR_W(8)) ifB ();

    d_memory_param #(
        .DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYC(0), .INIT_VAL(16'hA5A5)
    ) u0 (
        .clk(clk),
        .rst(rstA),
        .bus(ifA.slave)
    );

    d_memory_param #(
        .DATA_W(16), .ADDR_W(8), .DEPTH(16), .WAIT_CYC(3), .INIT_VAL(16'h0000)
    ) u1 (
        .clk(clk),
        .rst(rstB),
        .bus(ifB.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts post-reset cycles with busy high on A; ready must stay low throughout.
    task automatic countSweepA(output int busyCycles, output int readyHigh);
        busyCycles = 0;
        readyHigh  = 0;
        while (ifA.busy && busyCycles < 1000) begin
            busyCycles++;
            if (ifA.ready) readyHigh++;
            step();
        end
    endtask

    task automatic countSweepB(output int busyCycles, output int readyHigh, output int acks);
        busyCycles = 0;
        readyHigh  = 0;
        acks       = 0;
        while (ifB.busy && busyCycles < 1000) begin
            busyCycles++;
            if (ifB.ready) readyHigh++;
            if (ifB.ack) acks++;
            step();
        end
    endtask

    // Single access on A, returns cycles from acceptance to ack.
    task automatic accessA(input logic w, input logic [7:0] a, input logic [15:0] d,
                           output int lat, output logic [15:0] rd);
        int n = 0;
        while (!ifA.ready && n < 1000) begin
            step();
            n++;
        end
        ifA.req = 1'b1; ifA.we = w; ifA.addr = a; ifA.wdata = d;
        step();
        ifA.req = 1'b0;
        lat = 1;
        while (!ifA.ack && lat < 20) begin
            step();
            lat++;
        end
        rd = ifA.rdata;
    endtask

    // Single access on B; optionally pulses a write request during the wait states.
    task automatic accessB(input logic w, input logic [7:0] a, input logic [15:0] d, input bit pulse,
                           output int lat, output int readyHigh, output logic [15:0] rd,
                           output logic errSeen);
        int n = 0;
        while (!ifB.ready && n < 1000) begin
            step();
            n++;
        end
        ifB.req = 1'b1; ifB.we = w; ifB.addr = a; ifB.wdata = d;
        step();
        ifB.req   = 1'b0;
        lat       = 1;
        readyHigh = 0;
        while (!ifB.ack && lat < 20) begin
            if (ifB.ready) readyHigh++;
            if (pulse && lat == 1) begin
                ifB.req = 1'b1; ifB.we = 1'b1; ifB.addr = a; ifB.wdata = 16'hFFFF;
            end else begin
                ifB.req = 1'b0;
            end
            step();
            lat++;
        end
        ifB.req = 1'b0;
        rd = ifB.rdata;
`ifdef DMEM_BOUNDS_CHK_EN
        errSeen = ifB.err;
`else
        errSeen = 1'b0;
`endif
    endtask

    task automatic test_reset();
        int bc, rh, lat;
        logic [15:0] rd;
        checks++;
        if ({ifA.ready, ifA.ack, ifA.busy} !== 3'b001 || ifA.rdata !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL reset_state_A: got rdy/ack/busy=%b rdata=%h expected 001 0000",
                     {ifA.ready, ifA.ack, ifA.busy}, ifA.rdata);
        end
        checks++;
        if ({ifB.ready, ifB.ack, ifB.busy} !== 3'b001 || ifB.rdata !== 16'h0000) begin
            fails++;
            $display("[TB] FAIL reset_state_B: got rdy/ack/busy=%b rdata=%h expected 001 0000",
                     {ifB.ready, ifB.ack, ifB.busy}, ifB.rdata);
        end
        rstA = 1'b0;
        rstB = 1'b0;
        countSweepA(bc, rh);
        checks++;
        if (bc !== 256) begin
            fails++;
            $display("[TB] FAIL sweep_len_A: got %0d expected 256", bc);
        end
        checks++;
        if (rh !== 0) begin
            fails++;
            $display("[TB] FAIL sweep_ready_A: ready high %0d cycles, expected 0", rh);
        end
        accessA(1'b1, 8'd5, 16'h1234, lat, rd);
        accessA(1'b0, 8'd5, 16'h0000, lat, rd);
        checks++;
        if (rd !== 16'h1234) begin
            fails++;
            $display("[TB] FAIL write_read_5: got %h expected 1234", rd);
        end
        step();
        rstA = 1'b1;
        step();
        step();
        checks++;
        if (ifA.rdata !== 16'h0000 || ifA.busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rereset_A: got rdata=%h busy=%b expected 0000 1", ifA.rdata, ifA.busy);
        end
        rstA = 1'b0;
        countSweepA(bc, rh);
        checks++;
        if (bc !== 256 || rh !== 0) begin
            fails++;
            $display("[TB] FAIL resweep_A: got busy=%0d readyHigh=%0d expected 256 0", bc, rh);
        end
        accessA(1'b0, 8'd5, 16'h0000, lat, rd);
        checks++;
        if (rd !== 16'hA5A5) begin
            fails++;
            $display("[TB] FAIL sweep_value_5: got %h expected a5a5", rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] rd;
        ifA.req = 1'b1; ifA.we = 1'b1; ifA.addr = 8'd2; ifA.wdata = 16'd325;
        step();
        checks++;
        if (ifA.ack !== 1'b1 || ifA.ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_write_ack: got ack=%b ready=%b expected 1 1", ifA.ack, ifA.ready);
        end
        ifA.we = 1'b0;
        step();
        checks++;
        if (ifA.ack !== 1'b1 || ifA.ready !== 1'b1 || ifA.rdata !== 16'd325) begin
            fails++;
            $display("[TB] FAIL b2b_read: got ack=%b ready=%b rdata=%0d expected 1 1 325",
                     ifA.ack, ifA.ready, ifA.rdata);
        end
        ifA.we = 1'b1; ifA.addr = 8'd7; ifA.wdata = 16'hBEEF;
        step();
        checks++;
        if (ifA.ack !== 1'b1 || ifA.rdata !== 16'd325) begin
            fails++;
            $display("[TB] FAIL write_keeps_rdata: got ack=%b rdata=%h expected 1 0145", ifA.ack, ifA.rdata);
        end
        ifA.req = 1'b0;
        step();
        checks++;
        if (ifA.ack !== 1'b0 || ifA.ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ack_single_pulse: got ack=%b ready=%b expected 0 1", ifA.ack, ifA.ready);
        end
        accessA(1'b0, 8'd7, 16'h0000, lat, rd);
        checks++;
        if (rd !== 16'hBEEF || lat !== 1) begin
            fails++;
            $display("[TB] FAIL read_7: got %h lat=%0d expected beef 1", rd, lat);
        end
    endtask

    task automatic test_wait_states();
        int lat, rh;
        logic [15:0] rd;
        logic e;
        accessB(1'b1, 8'd0, 16'h00AB, 1'b0, lat, rh, rd, e);
        checks++;
        if (lat !== 4 || rh !== 0) begin
            fails++;
            $display("[TB] FAIL wait_write: got lat=%0d readyHigh=%0d expected 4 0", lat, rh);
        end
        accessB(1'b0, 8'd0, 16'h0000, 1'b1, lat, rh, rd, e);
        checks++;
        if (lat !== 4 || rh !== 0 || rd !== 16'h00AB) begin
            fails++;
            $display("[TB] FAIL wait_read: got lat=%0d readyHigh=%0d rdata=%h expected 4 0 00ab", lat, rh, rd);
        end
        step();
        checks++;
        if (ifB.ack !== 1'b0 || ifB.ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL wait_after_resp: got ack=%b ready=%b expected 0 1", ifB.ack, ifB.ready);
        end
        accessB(1'b0, 8'd0, 16'h0000, 1'b0, lat, rh, rd, e);
        checks++;
        if (rd !== 16'h00AB) begin
            fails++;
            $display("[TB] FAIL wait_pulse_ignored: got %h expected 00ab", rd);
        end
    endtask

    task automatic test_wrap();
        int lat, rh;
        logic [15:0] rd;
        logic e;
        accessB(1'b1, 8'h03, 16'h1111, 1'b0, lat, rh, rd, e);
        accessB(1'b1, 8'h13, 16'h3C00, 1'b0, lat, rh, rd, e);
`ifdef DMEM_BOUNDS_CHK_EN
        checks++;
        if (e !== 1'b1) begin
            fails++;
            $display("[TB] FAIL oob_write_err: got %b expected 1", e);
        end
        accessB(1'b0, 8'h03, 16'h0000, 1'b0, lat, rh, rd, e);
        checks++;
        if (rd !== 16'h1111 || e !== 1'b0) begin
            fails++;
            $display("[TB] FAIL oob_no_alias: got rdata=%h err=%b expected 1111 0", rd, e);
        end
        accessB(1'b0, 8'h13, 16'h0000, 1'b0, lat, rh, rd, e);
        checks++;
        if (rd !== 16'h0000 || e !== 1'b1) begin
            fails++;
            $display("[TB] FAIL oob_read: got rdata=%h err=%b expected 0000 1", rd, e);
        end
        step();
        checks++;
        if (ifB.err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL err_clears: got %b expected 0", ifB.err);
        end
`else
        accessB(1'b0, 8'h03, 16'h0000, 1'b0, lat, rh, rd, e);
        checks++;
        if (rd !== 16'h3C00) begin
            fails++;
            $display("[TB] FAIL wrap_read_3: got %h expected 3c00", rd);
        end
        accessB(1'b0, 8'hF3, 16'h0000, 1'b0, lat, rh, rd, e);
        checks++;
        if (rd !== 16'h3C00) begin
            fails++;
            $display("[TB] FAIL wrap_read_f3: got %h expected 3c00", rd);
        end
`endif
    endtask

    task automatic test_reset_mid_op();
        int bc, rh, acks, lat;
        logic [15:0] rd;
        logic e;
        ifB.req = 1'b1; ifB.we = 1'b0; ifB.addr = 8'd0;
        step();
        ifB.req = 1'b0;
        step();
        rstB = 1'b1;
        step();
        checks++;
        if (ifB.ack !== 1'b0 || ifB.rdata !== 16'h0000 || ifB.busy !== 1'b1 || ifB.ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midop_reset: got ack=%b rdata=%h busy=%b ready=%b expected 0 0000 1 0",
                     ifB.ack, ifB.rdata, ifB.busy, ifB.ready);
        end
        rstB = 1'b0;
        countSweepB(bc, rh, acks);
        checks++;
        if (bc !== 16 || rh !== 0 || acks !== 0) begin
            fails++;
            $display("[TB] FAIL midop_sweep: got busy=%0d readyHigh=%0d acks=%0d expected 16 0 0", bc, rh, acks);
        end
        accessB(1'b0, 8'd0, 16'h0000, 1'b0, lat, rh, rd, e);
        checks++;
        if (rd !== 16'h0000 || lat !== 4) begin
            fails++;
            $display("[TB] FAIL midop_cleared: got rdata=%h lat=%0d expected 0000 4", rd, lat);
        end
    endtask

    initial begin
        rstA = 1'b1;
        rstB = 1'b1;
        ifA.req = 1'b0; ifA.we = 1'b0; ifA.addr = '0; ifA.wdata = '0;
        ifB.req = 1'b0; ifB.we = 1'b0; ifB.addr = '0; ifB.wdata = '0;
        step();
        step();
        $display("[TB] starting directed tests");
        test_reset();
        test_back_to_back();
        test_wait_states();
        test_wrap();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
